// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out shifter.
package piso_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int CNT_W(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-word holding register with a full flag, used to queue the next frame
// while the current one is still shifting out.
module piso_hold_reg
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             take,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // Capture a word on load, release it on take; load and take never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter with ready/valid load, selectable bit order,
// external bit-rate tick and an optional holding register for gap-free frames.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no frame; ser_out at IDLE_LEVEL, a load starts a frame
//   S_SHIFT | frame on the line; each shift_en tick consumes one bit
module piso_shifter
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter bit   BUFFERED   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = CNT_W(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] shifted;
  logic             ser_d;
  logic             last_tick;
  logic             accept;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_load;
  logic             hold_take;

  assign last_tick = (state_q == S_SHIFT) && shift_en && (cnt_q == '0);

  // Without a buffer the port only opens when the shift register is free
  // or is being vacated on this very edge.
  assign load_ready = BUFFERED ? ~hold_full : ((state_q == S_IDLE) || last_tick);
  assign accept     = load_valid && load_ready;

  assign busy      = (state_q == S_SHIFT);
  assign ser_valid = (state_q == S_SHIFT);

  generate
    if (BUFFERED) begin : g_hold
      piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .load_data (load_data),
        .take      (hold_take),
        .data      (hold_data),
        .full      (hold_full)
      );
    end else begin : g_nohold
      assign hold_full = 1'b0;
      assign hold_data = '0;
      logic unused_hold;
      assign unused_hold = hold_load ^ hold_take;
    end
  endgenerate

  // Next-state, counter, shift-register and holding-register control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    hold_load = 1'b0;
    hold_take = 1'b0;
    if (MSB_FIRST) shifted = {sreg_q[WIDTH-2:0], 1'b0};
    else           shifted = {1'b0, sreg_q[WIDTH-1:1]};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sreg_d  = load_data;
          cnt_d   = CNT_MAX;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift_en) begin
          if (cnt_q != '0) begin
            sreg_d = shifted;
            cnt_d  = cnt_q - CW'(1);
          end else if (hold_full) begin
            sreg_d    = hold_data;
            cnt_d     = CNT_MAX;
            hold_take = 1'b1;
          end else if (accept) begin
            sreg_d = load_data;
            cnt_d  = CNT_MAX;
          end else begin
            state_d = S_IDLE;
          end
        end
        // A word accepted mid-frame is parked unless it went straight in.
        hold_load = accept && !(last_tick && !hold_full);
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_SHIFT) ser_d = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
    else                    ser_d = IDLE_LEVEL;
  end

  // State, counter, shift register and registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sreg_q     <= '0;
      ser_out    <= IDLE_LEVEL;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      ser_out    <= ser_d;
      frame_done <= last_tick;
    end
  end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter: three instances (MSB-first buffered,
// LSB-first buffered, MSB-first unbuffered) share clock, reset and inputs.
module tb_piso_shifter;

  logic       clk;
  logic       rst;
  logic       lv;
  logic [7:0] ld;
  logic       se;

  logic ready_a, ser_a, sv_a, busy_a, fd_a;
  logic ready_b, ser_b, sv_b, busy_b, fd_b;
  logic ready_c, ser_c, sv_c, busy_c, fd_c;

  int total = 0;
  int bad   = 0;

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .BUFFERED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(ready_a), .load_data(ld),
    .shift_en(se), .ser_out(ser_a), .ser_valid(sv_a), .busy(busy_a), .frame_done(fd_a));

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .BUFFERED(1'b1)) dut_b (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(ready_b), .load_data(ld),
    .shift_en(se), .ser_out(ser_b), .ser_valid(sv_b), .busy(busy_b), .frame_done(fd_b));

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .BUFFERED(1'b0)) dut_c (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(ready_c), .load_data(ld),
    .shift_en(se), .ser_out(ser_c), .ser_valid(sv_c), .busy(busy_c), .frame_done(fd_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; lv = 1'b0; ld = 8'h00; se = 1'b0;
    #2;
    total++; if (ser_a !== 1'b0)   begin bad++; $display("FAIL reset_ser got=%b exp=0", ser_a); end
    total++; if (sv_a !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b exp=0", sv_a); end
    total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    total++; if (fd_a !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", fd_a); end
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready_a got=%b exp=1", ready_a); end
    total++; if (ready_c !== 1'b1) begin bad++; $display("FAIL reset_ready_c got=%b exp=1", ready_c); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({busy_a, busy_b, busy_c, fd_a} !== 4'b0000)
      begin bad++; $display("FAIL idle_after_release got=%b exp=0000", {busy_a, busy_b, busy_c, fd_a}); end
    total++; if ({ser_a, ser_b, ser_c} !== 3'b000)
      begin bad++; $display("FAIL idle_level got=%b exp=000", {ser_a, ser_b, ser_c}); end
  endtask

  // 0x93 through both bit orders with shift_en tied high.
  task automatic test_bit_order();
    logic [7:0] w;
    w = 8'h93;
    lv = 1'b1; ld = w; se = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j < 8) begin
        total++; if (ser_a !== w[7-j]) begin bad++; $display("FAIL msb_bit%0d got=%b exp=%b", j, ser_a, w[7-j]); end
        total++; if (ser_b !== w[j])   begin bad++; $display("FAIL lsb_bit%0d got=%b exp=%b", j, ser_b, w[j]); end
        total++; if (sv_a !== 1'b1 || sv_b !== 1'b1)
          begin bad++; $display("FAIL order_valid%0d got=%b%b exp=11", j, sv_a, sv_b); end
      end
      total++; if (fd_a !== (j == 8) || fd_b !== (j == 8))
        begin bad++; $display("FAIL order_done%0d got=%b%b exp=%b", j, fd_a, fd_b, (j == 8)); end
      if (j == 8) begin
        total++; if (busy_a !== 1'b0 || ser_a !== 1'b0 || busy_b !== 1'b0 || ser_b !== 1'b0)
          begin bad++; $display("FAIL order_end got=%b%b%b%b exp=0000", busy_a, ser_a, busy_b, ser_b); end
      end
      if (j == 0) lv = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // Buffered back-to-back: 0x93 then 0xA5 with load_valid held.
  task automatic test_back_to_back();
    logic [15:0] w;
    w = 16'h93A5;
    lv = 1'b1; ld = 8'h93; se = 1'b1;
    @(posedge clk);
    #1 ld = 8'hA5;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i < 16) begin
        total++; if (ser_a !== w[15-i] || sv_a !== 1'b1)
          begin bad++; $display("FAIL b2b_bit%0d got=%b/%b exp=%b/1", i, ser_a, sv_a, w[15-i]); end
        total++; if (ready_a !== (i == 0 || i >= 8))
          begin bad++; $display("FAIL b2b_ready%0d got=%b exp=%b", i, ready_a, (i == 0 || i >= 8)); end
      end else if (i == 16) begin
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_end_busy got=%b exp=0", busy_a); end
      end
      total++; if (fd_a !== (i == 8 || i == 16))
        begin bad++; $display("FAIL b2b_done%0d got=%b exp=%b", i, fd_a, (i == 8 || i == 16)); end
      if (i == 1) lv = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // Bit-rate tick every 4th cycle: each bit of 0x0F held four cycles.
  task automatic test_slow_rate();
    logic [7:0] w;
    w = 8'h0F;
    lv = 1'b1; ld = w; se = 1'b0;
    for (int j = 0; j < 34; j++) begin
      @(negedge clk);
      if (j < 32) begin
        total++; if (ser_a !== w[7-(j/4)] || sv_a !== 1'b1)
          begin bad++; $display("FAIL slow_bit c%0d got=%b/%b exp=%b/1", j, ser_a, sv_a, w[7-(j/4)]); end
      end else if (j == 32) begin
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL slow_end_busy got=%b exp=0", busy_a); end
      end
      total++; if (fd_a !== (j == 32))
        begin bad++; $display("FAIL slow_done c%0d got=%b exp=%b", j, fd_a, (j == 32)); end
      lv = 1'b0;
      se = ((j + 1) % 4 == 0);
    end
    se = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Unbuffered: 0x55 waits for the last-bit tick of 0x93, then follows with no gap.
  task automatic test_unbuffered();
    logic [15:0] w;
    w = 16'h9355;
    lv = 1'b1; ld = 8'h93; se = 1'b1;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (j == 0) ld = 8'h55;
      if (j < 16) begin
        total++; if (ser_c !== w[15-j] || sv_c !== 1'b1)
          begin bad++; $display("FAIL unbuf_bit%0d got=%b/%b exp=%b/1", j, ser_c, sv_c, w[15-j]); end
        total++; if (ready_c !== (j == 7 || j == 15))
          begin bad++; $display("FAIL unbuf_ready%0d got=%b exp=%b", j, ready_c, (j == 7 || j == 15)); end
      end else if (j == 16) begin
        total++; if (busy_c !== 1'b0) begin bad++; $display("FAIL unbuf_end_busy got=%b exp=0", busy_c); end
      end
      total++; if (fd_c !== (j == 8 || j == 16))
        begin bad++; $display("FAIL unbuf_done%0d got=%b exp=%b", j, fd_c, (j == 8 || j == 16)); end
      if (j == 8) lv = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // Reset three bits into a 0xFF frame, then a fresh full frame.
  task automatic test_mid_reset();
    lv = 1'b1; ld = 8'hFF; se = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      lv = 1'b0;
      total++; if (ser_a !== 1'b1 || sv_a !== 1'b1)
        begin bad++; $display("FAIL pre_rst_bit%0d got=%b/%b exp=1/1", j, ser_a, sv_a); end
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (ser_a !== 1'b0 || sv_a !== 1'b0 || busy_a !== 1'b0)
      begin bad++; $display("FAIL rst_async_out got=%b%b%b exp=000", ser_a, sv_a, busy_a); end
    total++; if (ready_a !== 1'b1 || ready_c !== 1'b1)
      begin bad++; $display("FAIL rst_async_ready got=%b%b exp=11", ready_a, ready_c); end
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      total++; if (fd_a !== 1'b0 || busy_a !== 1'b0)
        begin bad++; $display("FAIL rst_no_done%0d got=%b/%b exp=0/0", j, fd_a, busy_a); end
    end
    lv = 1'b1; ld = 8'hFF;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      lv = 1'b0;
      if (j < 8) begin
        total++; if (ser_a !== 1'b1 || sv_a !== 1'b1)
          begin bad++; $display("FAIL reload_bit%0d got=%b/%b exp=1/1", j, ser_a, sv_a); end
      end else if (j == 8) begin
        total++; if (busy_a !== 1'b0 || ser_a !== 1'b0)
          begin bad++; $display("FAIL reload_end got=%b%b exp=00", busy_a, ser_a); end
      end
      total++; if (fd_a !== (j == 8))
        begin bad++; $display("FAIL reload_done%0d got=%b exp=%b", j, fd_a, (j == 8)); end
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_back_to_back();
    test_slow_rate();
    test_unbuffered();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
